descpt_feeder: RTL and testbench

- Responder side of the image-descriptor request/valid handshake used by the matching engine.
- On each descriptor_request it fetches the next group of four image keypoint descriptors (row, col, descriptor; 403 bits each) from a 4-bank image descriptor memory.
- It registers the four words onto image_R_C_D_0..3 and pulses descriptor_valid for one cycle.
- It sits between the image descriptor memory and the matcher, and tracks group count, exhaustion and overrun.

---
 rtl/descpt_feeder_if.sv | 56 +++++
 rtl/descpt_feeder.sv | 167 ++++++++++++++++
 tb/tb_descpt_feeder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/descpt_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : descpt_feeder_if
// Description : Bundle of the control, matcher-handshake and image-descriptor
//               memory signals around descpt_feeder.
//               slave  - the feeder's view (descpt_feeder ports).
//               master - the environment's view (matcher + memory + control).
// Signals     : start, kpt_num            - arm / keypoint count
//               descriptor_request/valid  - matcher handshake
//               image_R_C_D_0..3          - registered descriptor group
//               img_addr, img_rd_en       - shared address / read enable
//               img_dout_0..3             - per-bank read data
//               grp_served, all_served,
//               overrun                   - progress / status
// Revision    : 1.0 - initial release
// ============================================================================
interface descpt_feeder_if #(
    parameter int GRP_W = 9
);
    localparam int c_DW = 403;

    logic                 start;
    logic [10:0]          kpt_num;
    logic                 descriptor_request;
    logic                 descriptor_valid;
    logic [c_DW-1:0]      image_R_C_D_0;
    logic [c_DW-1:0]      image_R_C_D_1;
    logic [c_DW-1:0]      image_R_C_D_2;
    logic [c_DW-1:0]      image_R_C_D_3;
    logic [GRP_W-1:0]     img_addr;
    logic                 img_rd_en;
    logic [c_DW-1:0]      img_dout_0;
    logic [c_DW-1:0]      img_dout_1;
    logic [c_DW-1:0]      img_dout_2;
    logic [c_DW-1:0]      img_dout_3;
    logic [GRP_W-1:0]     grp_served;
    logic                 all_served;
    logic                 overrun;

    modport slave (
        input  start, kpt_num, descriptor_request,
        input  img_dout_0, img_dout_1, img_dout_2, img_dout_3,
        output descriptor_valid,
        output image_R_C_D_0, image_R_C_D_1, image_R_C_D_2, image_R_C_D_3,
        output img_addr, img_rd_en, grp_served, all_served, overrun
    );

    modport master (
        output start, kpt_num, descriptor_request,
        output img_dout_0, img_dout_1, img_dout_2, img_dout_3,
        input  descriptor_valid,
        input  image_R_C_D_0, image_R_C_D_1, image_R_C_D_2, image_R_C_D_3,
        input  img_addr, img_rd_en, grp_served, all_served, overrun
    );
endinterface
`default_nettype wire

// File: rtl/descpt_feeder.sv
`default_nettype none
// ============================================================================
// Module      : descpt_feeder
// Description : Responder for the matcher's descriptor request/valid
//               handshake. Each request fetches the next group of four
//               403-bit image keypoint descriptors from a 4-bank memory,
//               registers them on image_R_C_D_0..3 and pulses
//               descriptor_valid for one cycle. Tracks groups served,
//               exhaustion and overrun.
// Ports       : clk, rst_n (async, active-low)
//               bus (descpt_feeder_if.slave) - control, handshake, memory
//               and status signals.
// Parameters  : RD_LAT - memory read latency in cycles (1..3)
//               GRP_W  - group pointer / memory address width
// Revision    : 1.0 - initial release
// ============================================================================
module descpt_feeder #(
    parameter int RD_LAT = 1,
    parameter int GRP_W  = 9
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    descpt_feeder_if.slave   bus
);
    localparam int         c_DW   = 403;
    // Last FETCH cycle is the one in which the read data is valid.
    localparam logic [1:0] c_LAST = 2'(RD_LAT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_FETCH   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_clear;
    logic                w_load;
    logic                w_load_zero;

    logic [1:0]          r_lat_cnt;
    logic [GRP_W-1:0]    r_ptr;
    logic [GRP_W-1:0]    r_grp_num;
    logic [GRP_W-1:0]    r_served;
    logic                r_overrun;
    logic [c_DW-1:0]     r_rcd  [4];
    logic [c_DW-1:0]     w_dout [4];
    logic [GRP_W-1:0]    w_kpt_grp;

    // Trailing kpt_num % 4 keypoints are dropped, as the matcher does.
    assign w_kpt_grp = GRP_W'(bus.kpt_num >> 2);

    assign w_dout[0] = bus.img_dout_0;
    assign w_dout[1] = bus.img_dout_1;
    assign w_dout[2] = bus.img_dout_2;
    assign w_dout[3] = bus.img_dout_3;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM next state ----------------
    // start wins over everything, including a fetch in flight: the pending
    // read data is simply never captured.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_load_zero  = 1'b0;
        if (bus.start) begin
            w_next_state = ST_ARMED;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_IDLE;
                end
                ST_ARMED: begin
                    if (bus.descriptor_request) begin
                        if (r_ptr == r_grp_num) begin
                            // Exhausted: answer with a zero group so the
                            // requester never deadlocks.
                            w_next_state = ST_PRESENT;
                            w_load_zero  = 1'b1;
                        end else begin
                            w_next_state = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (r_lat_cnt == c_LAST) begin
                        w_next_state = ST_PRESENT;
                        w_load       = 1'b1;
                    end
                end
                ST_PRESENT: begin
                    w_next_state = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!bus.descriptor_request) begin
                        w_next_state = ST_ARMED;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt <= 2'd0;
            r_ptr     <= '0;
            r_grp_num <= '0;
            r_served  <= '0;
            r_overrun <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_rcd[k] <= '0;
            end
        end else begin
            r_lat_cnt <= ((r_state == ST_FETCH) && (w_next_state == ST_FETCH))
                         ? r_lat_cnt + 2'd1 : 2'd0;
            if (w_clear) begin
                r_ptr     <= '0;
                r_served  <= '0;
                r_overrun <= 1'b0;
                r_grp_num <= w_kpt_grp;
            end else if (w_load) begin
                for (int k = 0; k < 4; k++) begin
                    r_rcd[k] <= w_dout[k];
                end
                r_ptr    <= r_ptr + 1'b1;
                r_served <= r_served + 1'b1;
            end else if (w_load_zero) begin
                for (int k = 0; k < 4; k++) begin
                    r_rcd[k] <= '0;
                end
                r_overrun <= 1'b1;
            end
        end
    end

    // ---------------- Outputs (registered state decode only) ----------------
    assign bus.descriptor_valid = (r_state == ST_PRESENT);
    assign bus.img_rd_en        = (r_state == ST_FETCH) && (r_lat_cnt == 2'd0);
    assign bus.img_addr         = r_ptr;
    assign bus.grp_served       = r_served;
    assign bus.overrun          = r_overrun;
    // Qualified by "armed" so the flag is low out of reset, where both
    // counters are zero but nothing has been started.
    assign bus.all_served       = (r_state != ST_IDLE) && (r_served == r_grp_num);
    assign bus.image_R_C_D_0    = r_rcd[0];
    assign bus.image_R_C_D_1    = r_rcd[1];
    assign bus.image_R_C_D_2    = r_rcd[2];
    assign bus.image_R_C_D_3    = r_rcd[3];

endmodule
`default_nettype wire

// File: tb/tb_descpt_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_descpt_feeder
// Description : Self-checking bench for descpt_feeder. Instance 1 uses
//               RD_LAT=1, instance 2 uses RD_LAT=2 for the abort case.
//               Expected groups are queued when a request is issued and
//               compared when descriptor_valid appears on instance 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_descpt_feeder;
    localparam int DW = 403;
    localparam int GW = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n1;
    logic rst_n2;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [3:0][DW-1:0] d;
        logic [GW-1:0]      served;
        logic               all;
        logic               ovr;
    } exp_t;

    exp_t q[$];

    descpt_feeder_if #(.GRP_W(GW)) if1 ();
    descpt_feeder_if #(.GRP_W(GW)) if2 ();

    descpt_feeder #(.RD_LAT(1), .GRP_W(GW)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (if1.slave)
    );

    descpt_feeder #(.RD_LAT(2), .GRP_W(GW)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n2),
        .bus   (if2.slave)
    );

    // Distinct, never-zero content per bank and address.
    function automatic logic [DW-1:0] mword(input int bank, input int addr);
        logic [415:0] t;
        for (int i = 0; i < 13; i++) begin
            t[i*32 +: 32] = 32'hC0DE0000 + 32'(bank) * 32'h1000 + 32'(addr) * 32'h11 + 32'(i);
        end
        return t[DW-1:0];
    endfunction

    function automatic logic [3:0][DW-1:0] grp(input int addr);
        logic [3:0][DW-1:0] r;
        for (int b = 0; b < 4; b++) r[b] = mword(b, addr);
        return r;
    endfunction

    function automatic exp_t mk(input logic [3:0][DW-1:0] d, input int s, input bit a, input bit o);
        exp_t r;
        r.d      = d;
        r.served = GW'(s);
        r.all    = a;
        r.ovr    = o;
        return r;
    endfunction

    // Memory models: data valid RD_LAT cycles after img_rd_en, all-ones
    // garbage otherwise.
    logic          m1_v = 1'b0;
    logic [GW-1:0] m1_a = '0;
    always @(posedge clk) begin
        m1_v <= if1.img_rd_en;
        m1_a <= if1.img_addr;
    end
    assign if1.img_dout_0 = m1_v ? mword(0, int'(m1_a)) : {DW{1'b1}};
    assign if1.img_dout_1 = m1_v ? mword(1, int'(m1_a)) : {DW{1'b1}};
    assign if1.img_dout_2 = m1_v ? mword(2, int'(m1_a)) : {DW{1'b1}};
    assign if1.img_dout_3 = m1_v ? mword(3, int'(m1_a)) : {DW{1'b1}};

    logic          m2_v0 = 1'b0, m2_v1 = 1'b0;
    logic [GW-1:0] m2_a0 = '0,   m2_a1 = '0;
    always @(posedge clk) begin
        m2_v0 <= if2.img_rd_en;
        m2_a0 <= if2.img_addr;
        m2_v1 <= m2_v0;
        m2_a1 <= m2_a0;
    end
    assign if2.img_dout_0 = m2_v1 ? mword(0, int'(m2_a1)) : {DW{1'b1}};
    assign if2.img_dout_1 = m2_v1 ? mword(1, int'(m2_a1)) : {DW{1'b1}};
    assign if2.img_dout_2 = m2_v1 ? mword(2, int'(m2_a1)) : {DW{1'b1}};
    assign if2.img_dout_3 = m2_v1 ? mword(3, int'(m2_a1)) : {DW{1'b1}};

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer for instance 1.
    always @(negedge clk) begin
        exp_t e;
        if (if1.descriptor_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", DW'(1), DW'(0));
            end else begin
                e = q.pop_front();
                check("rcd0", if1.image_R_C_D_0, e.d[0]);
                check("rcd1", if1.image_R_C_D_1, e.d[1]);
                check("rcd2", if1.image_R_C_D_2, e.d[2]);
                check("rcd3", if1.image_R_C_D_3, e.d[3]);
                check("grp_served", DW'(if1.grp_served), DW'(e.served));
                check("all_served", DW'(if1.all_served), DW'(e.all));
                check("overrun",    DW'(if1.overrun),    DW'(e.ovr));
            end
        end
    end

    // Called just after a rising edge; request held for 5 cycles.
    task automatic req1(input bit rd, input int addr, input exp_t e);
        q.push_back(e);
        if1.descriptor_request = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rd_en_t%0d", k), DW'(if1.img_rd_en), DW'(rd && (k == 1)));
            check($sformatf("valid_t%0d", k), DW'(if1.descriptor_valid),
                  DW'(rd ? (k == 3) : (k == 1)));
            if (rd && k == 1) check("img_addr", DW'(if1.img_addr), DW'(addr));
            if (k == 4) if1.descriptor_request = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic start1(input int kpt);
        if1.start   = 1'b1;
        if1.kpt_num = 11'(kpt);
        @(posedge clk); #1;
        if1.start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vk;
        int cnt;
        int ra;

        if1.start = 1'b0; if1.kpt_num = '0; if1.descriptor_request = 1'b0;
        if2.start = 1'b0; if2.kpt_num = '0; if2.descriptor_request = 1'b0;
        rst_n1 = 1'b0;
        rst_n2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  DW'(if1.descriptor_valid), DW'(0));
        check("rst_rd_en",  DW'(if1.img_rd_en),        DW'(0));
        check("rst_addr",   DW'(if1.img_addr),         DW'(0));
        check("rst_served", DW'(if1.grp_served),       DW'(0));
        check("rst_all",    DW'(if1.all_served),       DW'(0));
        check("rst_ovr",    DW'(if1.overrun),          DW'(0));
        check("rst_rcd0",   if1.image_R_C_D_0,         DW'(0));
        check("rst_rcd3",   if1.image_R_C_D_3,         DW'(0));
        @(posedge clk); #1;
        rst_n1 = 1'b1;
        rst_n2 = 1'b1;
        @(posedge clk); #1;

        // kpt_num = 8 -> two groups then exhaustion
        start1(8);
        @(negedge clk);
        check("armed_served", DW'(if1.grp_served), DW'(0));
        check("armed_all",    DW'(if1.all_served), DW'(0));
        @(posedge clk); #1;
        req1(1'b1, 0, mk(grp(0), 1, 1'b0, 1'b0));
        req1(1'b1, 1, mk(grp(1), 2, 1'b1, 1'b0));
        @(negedge clk);
        check("hold_rcd0", if1.image_R_C_D_0, mword(0, 1));
        @(posedge clk); #1;
        req1(1'b0, 0, mk('0, 2, 1'b1, 1'b1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovr_sticky", DW'(if1.overrun), DW'(1));
        check("zero_hold",  if1.image_R_C_D_2, DW'(0));
        @(posedge clk); #1;

        // kpt_num = 11 -> still two groups
        start1(11);
        @(negedge clk);
        check("restart_ovr",    DW'(if1.overrun),    DW'(0));
        check("restart_served", DW'(if1.grp_served), DW'(0));
        @(posedge clk); #1;
        req1(1'b1, 0, mk(grp(0), 1, 1'b0, 1'b0));
        req1(1'b1, 1, mk(grp(1), 2, 1'b1, 1'b0));
        req1(1'b0, 0, mk('0, 2, 1'b1, 1'b1));

        // kpt_num = 3 -> no groups at all
        start1(3);
        req1(1'b0, 0, mk('0, 0, 1'b1, 1'b1));

        // Abort mid-fetch on the RD_LAT=2 instance
        if2.start = 1'b1; if2.kpt_num = 11'd8;
        @(posedge clk); #1;
        if2.start = 1'b0;
        @(posedge clk); #1;
        if2.descriptor_request = 1'b1;
        vk = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (vk < 0 && if2.descriptor_valid === 1'b1) vk = k;
            if (k == 5) if2.descriptor_request = 1'b0;
        end
        check("d2_latency", DW'(vk), DW'(4));
        check("d2_rcd1",    if2.image_R_C_D_1, mword(1, 0));
        @(posedge clk); #1;
        if2.descriptor_request = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("d2_abort_rd_en", DW'(if2.img_rd_en), DW'(1));
        check("d2_abort_addr",  DW'(if2.img_addr),  DW'(1));
        @(posedge clk); #1;
        if2.start = 1'b1; if2.kpt_num = 11'd8;
        if2.descriptor_request = 1'b0;
        @(posedge clk); #1;
        if2.start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if2.descriptor_valid === 1'b1) cnt++;
        end
        check("d2_abort_novalid", DW'(cnt), DW'(0));
        check("d2_abort_rcd0",    if2.image_R_C_D_0, mword(0, 0));
        check("d2_abort_rcd3",    if2.image_R_C_D_3, mword(3, 0));
        check("d2_abort_served",  DW'(if2.grp_served), DW'(0));
        @(posedge clk); #1;
        if2.descriptor_request = 1'b1;
        vk = -1;
        ra = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ra < 0 && if2.img_rd_en === 1'b1) ra = int'(if2.img_addr);
            if (vk < 0 && if2.descriptor_valid === 1'b1) vk = k;
            if (k == 5) if2.descriptor_request = 1'b0;
        end
        check("d2_reread_addr", DW'(ra), DW'(0));
        check("d2_reread_lat",  DW'(vk), DW'(4));
        check("d2_reread_rcd2", if2.image_R_C_D_2, mword(2, 0));
        check("d2_reread_srv",  DW'(if2.grp_served), DW'(1));

        // Async reset in the middle of a fetch on instance 1
        start1(8);
        req1(1'b1, 0, mk(grp(0), 1, 1'b0, 1'b0));
        if1.descriptor_request = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rd_en", DW'(if1.img_rd_en), DW'(1));
        #2;
        rst_n1 = 1'b0;
        #1;
        check("arst_rcd0",   if1.image_R_C_D_0,        DW'(0));
        check("arst_rcd1",   if1.image_R_C_D_1,        DW'(0));
        check("arst_served", DW'(if1.grp_served),      DW'(0));
        check("arst_addr",   DW'(if1.img_addr),        DW'(0));
        check("arst_rd_en",  DW'(if1.img_rd_en),       DW'(0));
        check("arst_valid",  DW'(if1.descriptor_valid),DW'(0));
        @(posedge clk); #1;
        rst_n1 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if1.img_rd_en === 1'b1 || if1.descriptor_valid === 1'b1) cnt++;
        end
        check("idle_ignores_req", DW'(cnt), DW'(0));
        if1.descriptor_request = 1'b0;
        check("scoreboard_empty", DW'(q.size()), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
